// File: rtl/float_subtractor.sv
// float_subtractor: IEEE-754 single-precision subtractor z = x - y, multi-cycle FSM datapath
// Ports: clk; rst (async, active-low); in_valid/in_ready input handshake;
//        x (minuend), y (subtrahend); out_valid one-cycle pulse; z result (held);
//        overflow: 00 ok, 01 overflow to inf, 10 denormal result, 11 NaN/inf operand.
// Config: define FLOAT_SUB_FTZ_EN to flush denormal operands/results to signed zero.
module float_subtractor (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        out_valid,
    output logic [31:0] z,
    output logic [1:0]  overflow
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, DONE} state_t;
    state_t state, state_n;
    logic [31:0] xr, yr, res, spec_res, rnd_res;
    logic [1:0]  res_ovf, spec_ovf, rnd_ovf;
    logic        xs, ys, s;
    logic [9:0]  xe, ye, e, ef;
    // mantissa layout: {carry, hidden, frac[22:0], guard, round, sticky}
    logic [27:0] xm, ym, m;
    logic [7:0]  xexp, yexp;
    logic [22:0] xfrac, yfrac, ff;
    logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, special;
    logic        same, xge, zero_diff, inc;
    logic [24:0] mr;
    assign xexp  = xr[30:23];
    assign yexp  = yr[30:23];
    assign xfrac = xr[22:0];
    assign yfrac = yr[22:0];
    assign x_nan = xexp == 8'hFF && xfrac != 0;
    assign y_nan = yexp == 8'hFF && yfrac != 0;
    assign x_inf = xexp == 8'hFF && xfrac == 0;
    assign y_inf = yexp == 8'hFF && yfrac == 0;
`ifdef FLOAT_SUB_FTZ_EN
    assign x_zero = xexp == 0;
    assign y_zero = yexp == 0;
`else
    assign x_zero = xexp == 0 && xfrac == 0;
    assign y_zero = yexp == 0 && yfrac == 0;
`endif
    assign special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
    // yr already carries the inverted sign, so "same sign" here means opposite raw signs
    always_comb begin
        spec_res = (x_nan | y_nan | (x_inf & y_inf & (xr[31] != yr[31]))) ? 32'h7FC00000 :
                   x_inf ? xr :
                   y_inf ? yr :
                   (x_zero & y_zero) ? {xr[31] & yr[31], 31'd0} :
                   x_zero ? yr : xr;
        spec_ovf = (x_nan | y_nan | x_inf | y_inf) ? 2'b11 : 2'b00;
    end
    assign same      = xs == ys;
    assign xge       = xm >= ym;
    assign zero_diff = !same && xm == ym;
    assign inc       = m[2] & (m[3] | m[1] | m[0]);
    assign mr        = m[27:3] + 25'(inc);
    // rounding carry renormalizes; an unset hidden bit at e=1 is a denormal (field 0)
    assign ef        = mr[24] ? e + 10'd1 : (mr[23] ? e : 10'd0);
    assign ff        = mr[24] ? mr[23:1] : mr[22:0];
    always_comb begin
        rnd_ovf = ef >= 10'd255 ? 2'b01 : (ef == 0 && ff != 0) ? 2'b10 : 2'b00;
`ifdef FLOAT_SUB_FTZ_EN
        rnd_res = ef >= 10'd255 ? {s, 8'hFF, 23'd0} : (ef == 0) ? {s, 31'd0} : {s, ef[7:0], ff};
`else
        rnd_res = ef >= 10'd255 ? {s, 8'hFF, 23'd0} : {s, ef[7:0], ff};
`endif
    end
    assign in_ready = state == IDLE;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? UNPACK : IDLE;
            UNPACK:  state_n = special ? DONE : ALIGN;
            ALIGN:   state_n = xe == ye ? ADDSUB : ALIGN;
            ADDSUB:  state_n = zero_diff ? DONE : NORM;
            NORM:    state_n = (m[27] || (!m[26] && e > 10'd1)) ? NORM : ROUND;
            ROUND:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xr <= '0; yr <= '0; res <= '0; res_ovf <= '0;
            xs <= 1'b0; ys <= 1'b0; s <= 1'b0;
            xe <= '0; ye <= '0; e <= '0; xm <= '0; ym <= '0; m <= '0;
            z <= '0; overflow <= '0; out_valid <= 1'b0;
        end else begin
            out_valid <= state == DONE;
            case (state)
                IDLE: if (in_valid) begin
                    xr <= x;
                    yr <= {~y[31], y[30:0]};
                end
                UNPACK: begin
                    res     <= spec_res;
                    res_ovf <= spec_ovf;
                    xs <= xr[31];
                    ys <= yr[31];
                    xe <= xexp == 0 ? 10'd1 : {2'b00, xexp};
                    ye <= yexp == 0 ? 10'd1 : {2'b00, yexp};
                    xm <= {1'b0, xexp != 0, xfrac, 3'b000};
                    ym <= {1'b0, yexp != 0, yfrac, 3'b000};
                end
                ALIGN: if (xe < ye) begin
                    xm <= (ye - xe >= 10'd26) ? {27'd0, |xm} : {1'b0, xm[27:2], xm[1] | xm[0]};
                    xe <= (ye - xe >= 10'd26) ? ye : xe + 10'd1;
                end else if (ye < xe) begin
                    ym <= (xe - ye >= 10'd26) ? {27'd0, |ym} : {1'b0, ym[27:2], ym[1] | ym[0]};
                    ye <= (xe - ye >= 10'd26) ? xe : ye + 10'd1;
                end
                ADDSUB: begin
                    e       <= xe;
                    s       <= (same || xge) ? xs : ys;
                    m       <= same ? xm + ym : xge ? xm - ym : ym - xm;
                    res     <= '0;
                    res_ovf <= 2'b00;
                end
                NORM: if (m[27]) begin
                    m <= {1'b0, m[27:2], m[1] | m[0]};
                    e <= e + 10'd1;
                end else if (!m[26] && e > 10'd1) begin
                    m <= {m[26:0], 1'b0};
                    e <= e - 10'd1;
                end
                ROUND: begin
                    res     <= rnd_res;
                    res_ovf <= rnd_ovf;
                end
                DONE: begin
                    z        <= res;
                    overflow <= res_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_float_subtractor.sv
// tb_float_subtractor: directed self-checking bench for float_subtractor with an expected-result queue
module tb_float_subtractor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        in_ready, out_valid;
    logic [31:0] z;
    logic [1:0]  overflow;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [33:0] sb[$];

    float_subtractor dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .z(z), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ez, input logic [1:0] eo, input int busy_hold);
        logic [33:0] e;
        int n;
        sb.push_back({eo, ez});
        @(negedge clk);
        x = a; y = b; in_valid = 1'b1;
        @(negedge clk);
        check({tag, " busy"}, 34'(in_ready), 34'd0);
        // operands offered while busy must be ignored
        x = 32'h12345678; y = 32'h0BADF00D;
        repeat (busy_hold) @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check({tag, " valid"}, 34'(out_valid), 34'd1);
        check({tag, " result"}, {overflow, z}, e);
        @(negedge clk);
        check({tag, " pulse"}, 34'(out_valid), 34'd0);
        check({tag, " hold"}, {overflow, z}, e);
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        check("reset z/ovf", {overflow, z}, 34'd0);
        check("reset ready", 34'(in_ready), 34'd1);
        check("reset valid", 34'(out_valid), 34'd0);
        rst = 1'b1;
        op("3-1",        32'h40400000, 32'h3F800000, 32'h40000000, 2'b00, 2);
        op("1-1",        32'h3F800000, 32'h3F800000, 32'h00000000, 2'b00, 0);
        op("-0-+0",      32'h80000000, 32'h00000000, 32'h80000000, 2'b00, 0);
        op("+0-+0",      32'h00000000, 32'h00000000, 32'h00000000, 2'b00, 0);
        op("max-(-max)", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 2'b01, 0);
        op("inf-inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 2'b11, 0);
        op("nan-1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2'b11, 0);
        op("inf-1",      32'h7F800000, 32'h3F800000, 32'h7F800000, 2'b11, 0);
        op("1-inf",      32'h3F800000, 32'h7F800000, 32'hFF800000, 2'b11, 0);
        op("rne tie",    32'h3F800000, 32'h33000000, 32'h3F800000, 2'b00, 0);
        op("rne below",  32'h3F800000, 32'h33800001, 32'h3F7FFFFF, 2'b00, 0);
        op("sticky far", 32'h3F800000, 32'h30800000, 32'h3F800000, 2'b00, 0);
        op("1.5-(-2.5)", 32'h3FC00000, 32'hC0200000, 32'h40800000, 2'b00, 0);
        op("2-3",        32'h40000000, 32'h40400000, 32'hBF800000, 2'b00, 0);
        op("0-3",        32'h00000000, 32'h40400000, 32'hC0400000, 2'b00, 0);
`ifdef FLOAT_SUB_FTZ_EN
        op("denorm",     32'h00800000, 32'h00400000, 32'h00800000, 2'b00, 0);
`else
        op("denorm",     32'h00800000, 32'h00400000, 32'h00400000, 2'b10, 0);
`endif
        @(negedge clk);
        x = 32'h40400000; y = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort pulses", 34'(pulses), 34'd0);
        check("abort z/ovf", {overflow, z}, 34'd0);
        check("abort ready", 34'(in_ready), 34'd1);
        op("after abort", 32'h40400000, 32'h3F800000, 32'h40000000, 2'b00, 0);
        check("queue empty", 34'(sb.size()), 34'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
